park_trans: RTL and testbench

//  Forward Park transform for the FOC current loop: I_d = I_alpha*cos + I_beta*sin,
//  I_q = I_beta*cos - I_alpha*sin, IEEE-754 single precision.

---
 rtl/park_pkg.sv | 21 ++
 rtl/park_trans_lat_timer.sv | 29 ++
 rtl/park_trans.sv | 143 ++++++++++++++
 tb/tb_park_trans.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/park_pkg.sv
// Shared definitions for the Park / inverse Park FOC stages: state encoding,
// FP32 width, adder op-select codes and common FP32 constants.
package park_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } park_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [FP_W-1:0] ONE     = 32'h3F80_0000;
  localparam logic [FP_W-1:0] NEG_ONE = 32'hBF80_0000;
  localparam logic [FP_W-1:0] ZERO    = 32'h0000_0000;

endpackage

// File: rtl/park_trans_lat_timer.sv
// Load/expire latency counter shared by the Park-style stages. expired is high
// on the last cycle of a hold of 'limit' cycles while run is asserted.
module lat_timer #(
  parameter int CW = 6
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          load,
  input  logic          run,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] count;

  // load wins over run so the count restarts from zero on every state change
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == limit - 1'b1);

endmodule

// File: rtl/park_trans.sv
// Forward Park transform sequencer: drives the external FP multipliers/adders and
// captures I_d/I_q. Define PARK_BUSY_EN to add the busy and sticky ovr outputs.
module park_trans
  import park_pkg::*;
#(
  parameter int W        = FP_W,
  parameter int MULT_LAT = 12,
  parameter int ADD_LAT  = 12
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] I_alpha,
  input  logic [W-1:0] I_beta,
  input  logic [W-1:0] sin,
  input  logic [W-1:0] cos,
  input  logic [W-1:0] re_mult1,
  input  logic [W-1:0] re_mult2,
  input  logic [W-1:0] re_mult3,
  input  logic [W-1:0] re_mult4,
  input  logic [W-1:0] re_add1,
  input  logic [W-1:0] re_add2,
  output logic [W-1:0] mult1a,
  output logic [W-1:0] mult1b,
  output logic [W-1:0] mult2a,
  output logic [W-1:0] mult2b,
  output logic [W-1:0] mult3a,
  output logic [W-1:0] mult3b,
  output logic [W-1:0] mult4a,
  output logic [W-1:0] mult4b,
  output logic [W-1:0] add1a,
  output logic [W-1:0] add1b,
  output logic [W-1:0] add2a,
  output logic [W-1:0] add2b,
  output logic         isadd1,
  output logic         isadd2,
  output logic [W-1:0] I_d,
  output logic [W-1:0] I_q,
`ifdef PARK_BUSY_EN
  output logic         busy,
  output logic         ovr,
`endif
  output logic         ack
);

  localparam logic [5:0] MULT_LIM = 6'(MULT_LAT);
  localparam logic [5:0] ADD_LIM  = 6'(ADD_LAT);

  park_state_t state;
  logic        timer_load;
  logic        timer_run;
  logic        timer_expired;
  logic [5:0]  timer_limit;

  // The timer only runs in the two wait states, so it never wraps while idle
  assign timer_run   = (state == MULT) || (state == ADD);
  assign timer_limit = (state == MULT) ? MULT_LIM : ADD_LIM;
  assign timer_load  = ((state == IDLE) && en) || timer_expired || (state == DONE);

  lat_timer #(.CW(6)) u_timer (
    .sys_clk (sys_clk),
    .rst     (rst),
    .load    (timer_load),
    .run     (timer_run),
    .limit   (timer_limit),
    .expired (timer_expired)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mult1a <= '0;
      mult1b <= '0;
      mult2a <= '0;
      mult2b <= '0;
      mult3a <= '0;
      mult3b <= '0;
      mult4a <= '0;
      mult4b <= '0;
      add1a  <= '0;
      add1b  <= '0;
      add2a  <= '0;
      add2b  <= '0;
      isadd1 <= 1'b0;
      isadd2 <= 1'b0;
      I_d    <= '0;
      I_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            mult1a <= I_alpha;
            mult1b <= cos;
            mult2a <= I_beta;
            mult2b <= sin;
            mult3a <= I_alpha;
            mult3b <= sin;
            mult4a <= I_beta;
            mult4b <= cos;
            state  <= MULT;
          end
        end
        // I_d = a*cos + b*sin, I_q = b*cos - a*sin
        MULT: begin
          if (timer_expired) begin
            add1a  <= re_mult1;
            add1b  <= re_mult2;
            isadd1 <= OP_ADD;
            add2a  <= re_mult4;
            add2b  <= re_mult3;
            isadd2 <= OP_SUB;
            state  <= ADD;
          end
        end
        ADD: begin
          if (timer_expired) begin
            I_d   <= re_add1;
            I_q   <= re_add2;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ack = (state == DONE);

`ifdef PARK_BUSY_EN
  assign busy = (state != IDLE);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (en && busy) begin
      ovr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_park_trans.sv
// Bench for park_trans: behavioural FP multiplier/adder models with exact latency,
// a formula-level Park reference model, and a second fast instance (latency 1/1).
module tb_park_trans;

  localparam int W  = 32;
  localparam int ML = 12;
  localparam int AL = 12;

  int compared;
  int mismatched;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic en      = 1'b0;
  logic f_en    = 1'b0;

  logic [W-1:0] i_alpha, i_beta, sin_v, cos_v;
  logic [W-1:0] re_mult [4];
  logic [W-1:0] re_add  [2];
  logic [W-1:0] mop_a [4];
  logic [W-1:0] mop_b [4];
  logic [W-1:0] aop_a [2];
  logic [W-1:0] aop_b [2];
  logic [1:0]   isadd;
  logic [W-1:0] i_d, i_q;
  logic         ack;

  logic [W-1:0] f_alpha, f_beta, f_sin, f_cos;
  logic [W-1:0] f_re_mult [4];
  logic [W-1:0] f_re_add  [2];
  logic [W-1:0] f_mop_a [4];
  logic [W-1:0] f_mop_b [4];
  logic [W-1:0] f_aop_a [2];
  logic [W-1:0] f_aop_b [2];
  logic [1:0]   f_isadd;
  logic [W-1:0] f_i_d, f_i_q;
  logic         f_ack;

`ifdef PARK_BUSY_EN
  logic busy, ovr, f_busy, f_ovr;
`endif

  always #5 sys_clk = ~sys_clk;

  // FP32 helpers: exact widening to double, round-to-nearest-even narrowing
  function automatic real f2d(input logic [31:0] x);
    if (x[30:0] == 31'd0) return $bitstoreal({x[31], 63'd0});
    return $bitstoreal({x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] d2f(input real v);
    logic [63:0] b;
    logic [24:0] m;
    logic [8:0]  e;
    b = $realtobits(v);
    if (b[62:0] == 63'd0) return {b[63], 31'd0};
    e = 9'(int'(b[62:52]) - 1023 + 127);
    m = {2'b01, b[51:29]};
    if (b[28] && ((|b[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 9'd1;
    end
    return {b[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    return d2f(f2d(x) * f2d(y));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y, input logic sub);
    return d2f(sub ? (f2d(x) - f2d(y)) : (f2d(x) + f2d(y)));
  endfunction

  function automatic logic [31:0] rnd_fp(input int emin, input int emax);
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(emin, emax));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  function automatic int ulp_diff(input logic [31:0] x, input logic [31:0] y);
    int d;
    d = int'(x) - int'(y);
    return (d < 0) ? -d : d;
  endfunction

  // External FP units with exactly ML / AL cycles from operand register to capture
  logic [W-1:0] mpipe [4][ML-1];
  logic [W-1:0] apipe [2][AL-1];

  always @(posedge sys_clk) begin
    for (int u = 0; u < 4; u++) begin
      mpipe[u][0] <= fmul(mop_a[u], mop_b[u]);
      for (int k = 1; k < ML-1; k++) mpipe[u][k] <= mpipe[u][k-1];
    end
    for (int u = 0; u < 2; u++) begin
      apipe[u][0] <= fadd(aop_a[u], aop_b[u], isadd[u]);
      for (int k = 1; k < AL-1; k++) apipe[u][k] <= apipe[u][k-1];
    end
  end

  always_comb begin
    for (int u = 0; u < 4; u++) re_mult[u] = mpipe[u][ML-2];
    for (int u = 0; u < 2; u++) re_add[u] = apipe[u][AL-2];
    for (int u = 0; u < 4; u++) f_re_mult[u] = fmul(f_mop_a[u], f_mop_b[u]);
    for (int u = 0; u < 2; u++) f_re_add[u] = fadd(f_aop_a[u], f_aop_b[u], f_isadd[u]);
  end

  park_trans #(.W(W), .MULT_LAT(ML), .ADD_LAT(AL)) dut (
    .sys_clk (sys_clk), .rst (rst), .en (en),
    .I_alpha (i_alpha), .I_beta (i_beta), .sin (sin_v), .cos (cos_v),
    .re_mult1 (re_mult[0]), .re_mult2 (re_mult[1]), .re_mult3 (re_mult[2]), .re_mult4 (re_mult[3]),
    .re_add1 (re_add[0]), .re_add2 (re_add[1]),
    .mult1a (mop_a[0]), .mult1b (mop_b[0]), .mult2a (mop_a[1]), .mult2b (mop_b[1]),
    .mult3a (mop_a[2]), .mult3b (mop_b[2]), .mult4a (mop_a[3]), .mult4b (mop_b[3]),
    .add1a (aop_a[0]), .add1b (aop_b[0]), .add2a (aop_a[1]), .add2b (aop_b[1]),
    .isadd1 (isadd[0]), .isadd2 (isadd[1]),
    .I_d (i_d), .I_q (i_q),
`ifdef PARK_BUSY_EN
    .busy (busy), .ovr (ovr),
`endif
    .ack (ack)
  );

  park_trans #(.W(W), .MULT_LAT(1), .ADD_LAT(1)) dut_fast (
    .sys_clk (sys_clk), .rst (rst), .en (f_en),
    .I_alpha (f_alpha), .I_beta (f_beta), .sin (f_sin), .cos (f_cos),
    .re_mult1 (f_re_mult[0]), .re_mult2 (f_re_mult[1]), .re_mult3 (f_re_mult[2]), .re_mult4 (f_re_mult[3]),
    .re_add1 (f_re_add[0]), .re_add2 (f_re_add[1]),
    .mult1a (f_mop_a[0]), .mult1b (f_mop_b[0]), .mult2a (f_mop_a[1]), .mult2b (f_mop_b[1]),
    .mult3a (f_mop_a[2]), .mult3b (f_mop_b[2]), .mult4a (f_mop_a[3]), .mult4b (f_mop_b[3]),
    .add1a (f_aop_a[0]), .add1b (f_aop_b[0]), .add2a (f_aop_a[1]), .add2b (f_aop_b[1]),
    .isadd1 (f_isadd[0]), .isadd2 (f_isadd[1]),
    .I_d (f_i_d), .I_q (f_i_q),
`ifdef PARK_BUSY_EN
    .busy (f_busy), .ovr (f_ovr),
`endif
    .ack (f_ack)
  );

  // One transaction on the slow instance; lat = edges from accept to ack (0 = none)
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                       input logic [31:0] c, output int lat);
    @(posedge sys_clk);
    @(negedge sys_clk);
    i_alpha = a; i_beta = b; sin_v = s; cos_v = c; en = 1'b1;
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    en = 1'b0;
    i_alpha = $urandom; i_beta = $urandom; sin_v = $urandom; cos_v = $urandom;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge sys_clk);
      #1;
      if (ack) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    i_alpha = '0; i_beta = '0; sin_v = '0; cos_v = '0;
    f_alpha = '0; f_beta = '0; f_sin = '0; f_cos = '0;
    rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    compared++;
    if (ack !== 1'b0 || f_ack !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_ack: got %b/%b want 0/0", ack, f_ack);
    end
    compared++;
    if (i_d !== 32'h0 || i_q !== 32'h0) begin
      mismatched++; $display("[TB] FAIL reset_result: got %h/%h want 0/0", i_d, i_q);
    end
    compared++;
    if (isadd !== 2'b00 || mop_a[0] !== 32'h0 || mop_b[3] !== 32'h0 || aop_a[1] !== 32'h0) begin
      mismatched++; $display("[TB] FAIL reset_operands: isadd=%b m1a=%h m4b=%h a2a=%h want zeros",
                             isadd, mop_a[0], mop_b[3], aop_a[1]);
    end
`ifdef PARK_BUSY_EN
    compared++;
    if (busy !== 1'b0 || ovr !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_busy_ovr: got %b/%b want 0/0", busy, ovr);
    end
`endif
    @(negedge sys_clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    do_op(32'h3F80_0000, 32'h0, 32'h0, 32'h3F80_0000, lat);
    compared++;
    if (lat !== ML + AL) begin
      mismatched++; $display("[TB] FAIL basic1_latency: got %0d want %0d", lat, ML + AL);
    end
    compared++;
    if (i_d !== 32'h3F80_0000 || i_q !== 32'h0000_0000) begin
      mismatched++; $display("[TB] FAIL basic1_result: got %h/%h want 3f800000/00000000", i_d, i_q);
    end
    @(posedge sys_clk);
    #1;
    compared++;
    if (ack !== 1'b0) begin
      mismatched++; $display("[TB] FAIL ack_one_cycle: got %b want 0", ack);
    end
    do_op(32'h3F80_0000, 32'h0, 32'h3F80_0000, 32'h0, lat);
    compared++;
    if (i_d !== 32'h0000_0000 || i_q !== 32'hBF80_0000) begin
      mismatched++; $display("[TB] FAIL basic2_result: got %h/%h want 00000000/bf800000", i_d, i_q);
    end
    compared++;
    if (isadd !== 2'b10) begin
      mismatched++; $display("[TB] FAIL basic2_isadd: got %b want 10", isadd);
    end
  endtask

  task automatic test_random;
    int lat;
    logic [31:0] a, b, s, c, e_d, e_q;
    for (int k = 0; k < 6; k++) begin
      a = rnd_fp(122, 130); b = rnd_fp(122, 130);
      s = rnd_fp(122, 126); c = rnd_fp(122, 126);
      e_d = fadd(fmul(a, c), fmul(b, s), 1'b0);
      e_q = fadd(fmul(b, c), fmul(a, s), 1'b1);
      do_op(a, b, s, c, lat);
      compared++;
      if (lat !== ML + AL) begin
        mismatched++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", k, lat, ML + AL);
      end
      compared++;
      if (i_d !== e_d || i_q !== e_q) begin
        mismatched++; $display("[TB] FAIL rand%0d_result: got %h/%h want %h/%h", k, i_d, i_q, e_d, e_q);
      end
      compared++;
      if (mop_a[0] !== a || mop_b[0] !== c || mop_a[1] !== b || mop_b[1] !== s ||
          mop_a[2] !== a || mop_b[2] !== s || mop_a[3] !== b || mop_b[3] !== c) begin
        mismatched++; $display("[TB] FAIL rand%0d_mult_ops: got %h %h %h %h %h %h %h %h want %h %h %h %h %h %h %h %h",
          k, mop_a[0], mop_b[0], mop_a[1], mop_b[1], mop_a[2], mop_b[2], mop_a[3], mop_b[3],
          a, c, b, s, a, s, b, c);
      end
      compared++;
      if (aop_a[0] !== fmul(a, c) || aop_b[0] !== fmul(b, s) ||
          aop_a[1] !== fmul(b, c) || aop_b[1] !== fmul(a, s) || isadd !== 2'b10) begin
        mismatched++; $display("[TB] FAIL rand%0d_add_ops: got %h %h %h %h isadd=%b want %h %h %h %h isadd=10",
          k, aop_a[0], aop_b[0], aop_a[1], aop_b[1], isadd, fmul(a, c), fmul(b, s), fmul(b, c), fmul(a, s));
      end
    end
`ifdef PARK_BUSY_EN
    compared++;
    if (ovr !== 1'b0) begin
      mismatched++; $display("[TB] FAIL ovr_quiet: got %b want 0", ovr);
    end
`endif
  endtask

  task automatic test_round_trip;
    int lat;
    logic [31:0] ud, uq, c, s, ua, ub;
    ud = 32'h4000_0000;
    uq = 32'h3F00_0000;
    c  = d2f(0.8660254037844386);
    s  = 32'h3F00_0000;
    ua = fadd(fmul(ud, c), fmul(uq, s), 1'b1);
    ub = fadd(fmul(ud, s), fmul(uq, c), 1'b0);
    do_op(ua, ub, s, c, lat);
    compared++;
    if (ulp_diff(i_d, ud) > 2) begin
      mismatched++; $display("[TB] FAIL round_trip_d: got %h want %h within 2 ulp", i_d, ud);
    end
    compared++;
    if (ulp_diff(i_q, uq) > 2) begin
      mismatched++; $display("[TB] FAIL round_trip_q: got %h want %h within 2 ulp", i_q, uq);
    end
  endtask

  task automatic test_overrun;
    int acks, first;
    logic [31:0] a, b, s, c, e_d, e_q;
    a = rnd_fp(122, 130); b = rnd_fp(122, 130); s = rnd_fp(122, 126); c = rnd_fp(122, 126);
    e_d = fadd(fmul(a, c), fmul(b, s), 1'b0);
    e_q = fadd(fmul(b, c), fmul(a, s), 1'b1);
    @(posedge sys_clk);
    @(negedge sys_clk);
    i_alpha = a; i_beta = b; sin_v = s; cos_v = c; en = 1'b1;
    @(posedge sys_clk);
    acks = 0; first = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge sys_clk);
      en = (cyc == 5) || (cyc == 16);
      i_alpha = $urandom; i_beta = $urandom; sin_v = $urandom; cos_v = $urandom;
      @(posedge sys_clk);
      #1;
      if (ack) begin
        acks++;
        if (first == 0) first = cyc;
      end
`ifdef PARK_BUSY_EN
      if (cyc == 10) begin
        compared++;
        if (busy !== 1'b1) begin
          mismatched++; $display("[TB] FAIL overrun_busy: got %b want 1", busy);
        end
      end
`endif
    end
    compared++;
    if (acks !== 1 || first !== ML + AL) begin
      mismatched++; $display("[TB] FAIL overrun_acks: got %0d acks first at %0d want 1 at %0d", acks, first, ML + AL);
    end
    compared++;
    if (i_d !== e_d || i_q !== e_q || mop_a[0] !== a) begin
      mismatched++; $display("[TB] FAIL overrun_result: got %h/%h m1a=%h want %h/%h m1a=%h",
                             i_d, i_q, mop_a[0], e_d, e_q, a);
    end
`ifdef PARK_BUSY_EN
    compared++;
    if (ovr !== 1'b1 || busy !== 1'b0) begin
      mismatched++; $display("[TB] FAIL overrun_ovr: got ovr=%b busy=%b want 1/0", ovr, busy);
    end
`endif
  endtask

  task automatic test_reset_mid_add;
    int lat, stray;
    logic [31:0] a, b, s, c, e_d, e_q;
    @(posedge sys_clk);
    @(negedge sys_clk);
    i_alpha = rnd_fp(122, 130); i_beta = rnd_fp(122, 130);
    sin_v = rnd_fp(122, 126); cos_v = rnd_fp(122, 126); en = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    en = 1'b0;
    repeat (17) @(posedge sys_clk);
    #3;
    rst = 1'b1;
    #1;
    compared++;
    if (ack !== 1'b0 || i_d !== 32'h0 || i_q !== 32'h0 || isadd !== 2'b00) begin
      mismatched++; $display("[TB] FAIL midrst_outputs: ack=%b d=%h q=%h isadd=%b want zeros", ack, i_d, i_q, isadd);
    end
    compared++;
    if (mop_a[0] !== 32'h0 || mop_b[3] !== 32'h0 || aop_a[0] !== 32'h0 || aop_b[1] !== 32'h0) begin
      mismatched++; $display("[TB] FAIL midrst_operands: %h %h %h %h want zeros", mop_a[0], mop_b[3], aop_a[0], aop_b[1]);
    end
`ifdef PARK_BUSY_EN
    compared++;
    if (busy !== 1'b0 || ovr !== 1'b0) begin
      mismatched++; $display("[TB] FAIL midrst_busy_ovr: got %b/%b want 0/0", busy, ovr);
    end
`endif
    @(negedge sys_clk);
    rst = 1'b0;
    stray = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge sys_clk);
      #1;
      if (ack) stray++;
    end
    compared++;
    if (stray !== 0) begin
      mismatched++; $display("[TB] FAIL midrst_no_ack: got %0d acks want 0", stray);
    end
    a = rnd_fp(122, 130); b = rnd_fp(122, 130); s = rnd_fp(122, 126); c = rnd_fp(122, 126);
    e_d = fadd(fmul(a, c), fmul(b, s), 1'b0);
    e_q = fadd(fmul(b, c), fmul(a, s), 1'b1);
    do_op(a, b, s, c, lat);
    compared++;
    if (lat !== ML + AL || i_d !== e_d || i_q !== e_q) begin
      mismatched++; $display("[TB] FAIL midrst_recover: lat=%0d d=%h q=%h want lat=%0d d=%h q=%h",
                             lat, i_d, i_q, ML + AL, e_d, e_q);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit got;
    logic [31:0] a, b, s, c, e_d, e_q;
    @(negedge sys_clk);
    a = rnd_fp(122, 130); b = rnd_fp(122, 130); s = rnd_fp(122, 126); c = rnd_fp(122, 126);
    f_alpha = a; f_beta = b; f_sin = s; f_cos = c;
    e_d = fadd(fmul(a, c), fmul(b, s), 1'b0);
    e_q = fadd(fmul(b, c), fmul(a, s), 1'b1);
    f_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      got = 0; n = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(posedge sys_clk);
        #1;
        n++;
        if (f_ack) got = 1;
      end
      compared++;
      if (!got || n !== ((k == 0) ? 3 : 4)) begin
        mismatched++; $display("[TB] FAIL b2b%0d_spacing: got %0d edges (ack seen=%0d) want %0d",
                               k, n, got, (k == 0) ? 3 : 4);
      end
      compared++;
      if (f_i_d !== e_d || f_i_q !== e_q) begin
        mismatched++; $display("[TB] FAIL b2b%0d_result: got %h/%h want %h/%h", k, f_i_d, f_i_q, e_d, e_q);
      end
`ifdef PARK_BUSY_EN
      if (k == 5) begin
        compared++;
        if (f_busy !== 1'b1 || f_ovr !== 1'b1) begin
          mismatched++; $display("[TB] FAIL b2b_busy_ovr: got %b/%b want 1/1", f_busy, f_ovr);
        end
      end
`endif
      a = rnd_fp(122, 130); b = rnd_fp(122, 130); s = rnd_fp(122, 126); c = rnd_fp(122, 126);
      f_alpha = a; f_beta = b; f_sin = s; f_cos = c;
      e_d = fadd(fmul(a, c), fmul(b, s), 1'b0);
      e_q = fadd(fmul(b, c), fmul(a, s), 1'b1);
    end
    @(negedge sys_clk);
    f_en = 1'b0;
    repeat (6) @(posedge sys_clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset;
    test_basic;
    test_random;
    test_round_trip;
    test_overrun;
    test_reset_mid_add;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
